// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stage stall requests, sequences exception redirects.
// Latency: stall vector is combinational (zero latency); flush/redirect one cycle after exc_req at the earliest.
// Backpressure: an outstanding fetch (req_if) holds the redirect in WAIT_IF until it drains; later exc_req ignored.
module pipeline_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_if,
    input  logic              req_id,
    input  logic              req_ex,
    input  logic              req_mem,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              perf_clr,
    output logic [4:0]        stall,
    output logic              flush,
    output logic              redirect_en,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_IF = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    // Stall pattern that freezes PC..EX/MEM while MEM/WB drains (bubble into WB).
    localparam logic [4:0] STALL_HOLD = 5'b01111;

    state_t              state_q, state_d;
    logic                flush_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   redirect_pc_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          stall_merge;

    // Each stage's request stalls itself and every older stage behind it.
    always_comb begin
        stall_merge    = 5'b00000;
        stall_merge[0] = req_if | req_id | req_ex | req_mem;
        stall_merge[1] = req_id | req_ex | req_mem;
        stall_merge[2] = req_ex | req_mem;
        stall_merge[3] = req_mem;
    end

    // Stall vector and next state: exc_req in RUN overrides all stall requests.
    always_comb begin
        stall   = stall_merge;
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (exc_req) begin
                    stall   = STALL_HOLD;
                    state_d = req_if ? S_WAIT_IF : S_FLUSH;
                end
            end
            S_WAIT_IF: begin
                stall = STALL_HOLD;
                if (!req_if) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                stall   = 5'b00000;
                state_d = S_RUN;
            end
            default: begin
                stall   = 5'b00000;
                state_d = S_RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (perf_clr) begin
            cnt_d = '0;
        end else if (stall[0] && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM state plus registered Moore outputs; redirect target captured only when a new exception is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_d == S_FLUSH);
            busy_q  <= (state_d != S_RUN);
            if (state_q == S_RUN && exc_req) begin
                redirect_pc_q <= exc_pc;
            end
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign flush        = flush_q;
    assign redirect_en  = flush_q;
    assign busy         = busy_q;
    assign redirect_pc  = redirect_pc_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic against a behavioural model.
// Model is evaluated each cycle; outputs sampled on the falling edge, model advanced on the rising edge.
// Bounded run; every comparison is an immediate assertion feeding the failure count.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_if, req_id, req_ex, req_mem;
    logic              exc_req;
    logic [31:0]       exc_pc;
    logic              perf_clr;
    logic [4:0]        stall;
    logic              flush;
    logic              redirect_en;
    logic [31:0]       redirect_pc;
    logic              busy;
    logic [CNT_W-1:0]  stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what the pipe is doing, not how the RTL encodes it.
    bit          m_owned;      // an exception owns the pipe
    bit          m_flushing;   // this cycle is the redirect cycle
    logic [31:0] m_pc;
    int          m_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if),
        .req_id       (req_id),
        .req_ex       (req_ex),
        .req_mem      (req_mem),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .flush        (flush),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Youngest requesting stage k stalls stages 0..k-1 inclusive of itself: (2^n)-1.
    function automatic logic [4:0] exp_stall();
        int n;
        if (m_flushing) return 5'b00000;
        if (m_owned || exc_req) return 5'b01111;
        n = 0;
        if (req_if)  n = 1;
        if (req_id)  n = 2;
        if (req_ex)  n = 3;
        if (req_mem) n = 4;
        return 5'((1 << n) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [4:0] es;
        @(negedge clk);
        es = exp_stall();
        chk("stall",        32'(stall),        32'(es));
        chk("flush",        32'(flush),        32'(m_flushing));
        chk("redirect_en",  32'(redirect_en),  32'(m_flushing));
        chk("busy",         32'(busy),         32'(m_owned || m_flushing));
        chk("redirect_pc",  redirect_pc,       m_pc);
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_owned = 0; m_flushing = 0; m_pc = '0; m_cnt = 0;
        end else begin
            if (perf_clr)   m_cnt = 0;
            else if (es[0]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (m_flushing) begin
                m_flushing = 0;
            end else if (m_owned) begin
                if (!req_if) begin m_owned = 0; m_flushing = 1; end
            end else if (exc_req) begin
                m_pc = exc_pc;
                if (req_if) m_owned = 1;
                else        m_flushing = 1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        exc_req = 0; exc_pc = '0; perf_clr = 0; rst = 0;
    endtask

    initial begin
        m_owned = 0; m_flushing = 0; m_pc = '0; m_cnt = 0;
        idle_inputs();
        rst = 1;
        // 1) reset, two cycles
        step(); step();
        rst = 0;
        step();
        chk("reset_stall", 32'(stall), 32'h0);

        // 2) stall merge
        req_ex = 1;                step();
        req_mem = 1;               step();
        req_ex = 0; req_mem = 0;   step();
        perf_clr = 1; step(); perf_clr = 0;

        // 3) exception, no fetch outstanding: flush at T+1
        exc_req = 1; exc_pc = 32'hBFC00380; step();
        exc_req = 0; exc_pc = '0;
        @(negedge clk);
        chk("t3_flush",  32'(flush), 32'h1);
        chk("t3_pc",     redirect_pc, 32'hBFC00380);
        chk("t3_stall",  32'(stall), 32'h0);
        @(posedge clk); #1;
        m_flushing = 0;
        step();

        // 4) exception with fetch outstanding; second exception ignored
        req_if = 1; exc_req = 1; exc_pc = 32'h80000180; step();   // T
        exc_req = 0;                                    step();   // T+1
        exc_req = 1; exc_pc = 32'h80000000;             step();   // T+2
        exc_req = 0;                                    step();   // T+3
        req_if = 0;                                     step();   // T+4
        @(negedge clk);                                           // T+5
        chk("t4_flush", 32'(flush), 32'h1);
        chk("t4_pc",    redirect_pc, 32'h80000180);
        @(posedge clk); #1;
        m_flushing = 0;
        step();                                                   // T+6
        chk("t4_after", 32'(flush), 32'h0);

        // 5) counter saturation and clear
        perf_clr = 1; step(); perf_clr = 0;
        req_id = 1;
        for (int i = 0; i < 20; i++) step();
        req_id = 0;
        chk("t5_sat", 32'(stall_cycles), CMAX);
        perf_clr = 1; step(); perf_clr = 0;
        step();
        chk("t5_clr", 32'(stall_cycles), 32'h0);

        // 6) reset in WAIT_IF drops the redirect
        req_if = 1; exc_req = 1; exc_pc = 32'h12345678; step();
        exc_req = 0; step();
        rst = 1; step(); rst = 0;
        req_if = 0;
        chk("t6_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_noflush", 32'(flush), 32'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            req_if   = ($urandom_range(0, 2) == 0);
            req_id   = ($urandom_range(0, 4) == 0);
            req_ex   = ($urandom_range(0, 4) == 0);
            req_mem  = ($urandom_range(0, 4) == 0);
            exc_req  = ($urandom_range(0, 7) == 0);
            exc_pc   = $urandom;
            perf_clr = ($urandom_range(0, 40) == 0);
            rst      = ($urandom_range(0, 120) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
